ml_vec_dot_engine: RTL and testbench

ML_VEC_DOT_ENGINE -- requirements
Module: ml_vec_dot_engine

---
 rtl/ml_dot_pkg.sv | 25 ++
 rtl/ml_vec_dot_engine_mac.sv | 43 ++++
 rtl/ml_vec_dot_engine.sv | 156 +++++++++++++++
 tb/tb_ml_vec_dot_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_dot_pkg.sv
// Shared types, default widths and saturation bounds for the vector dot-product engine.
package ml_dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_OUT_W  = 32;
  localparam int DEF_CNT_W  = 16;

  // Largest value representable in a signed field of width w (1..64).
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed field of width w (1..64).
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/ml_vec_dot_engine_mac.sv
// Multiply and accumulate-or-load datapath: holds the running accumulator and
// exposes its next value so the top can capture the final sum on the last beat.
module ml_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_d
);

  logic signed [2*DATA_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]    prod_ext_p0;
  logic signed [ACC_W-1:0]    acc_q;

  // Full-precision product, sign-extended into the accumulator width
  always_comb begin
    prod_p0     = a * b;
    prod_ext_p0 = ACC_W'(prod_p0);
  end

  // First beat of a vector loads the product; later beats add with natural wrap
  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = load ? prod_ext_p0 : acc_q + prod_ext_p0;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/ml_vec_dot_engine.sv
// Streaming signed dot-product engine: accumulates a*b over one vector pair
// (terminated by in_last) and holds the result until the consumer takes it.
// Optional build macro ML_DOT_SAT_EN: clamp the result to the signed OUT_W
// range and flag clamping on out_sat; otherwise the result is truncated.
module ml_vec_dot_engine
  import ml_dot_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]         out_len,
  output logic                     out_sat
);

  state_t                  state_q, state_d;
  logic                    accept;
  logic                    load;
  logic signed [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] res_data;
  logic                    res_sat;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_len_q, out_len_d;
  logic                    out_sat_q, out_sat_d;

  assign accept = in_valid && in_ready;
  assign load   = (state_q == IDLE);

  ml_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .load  (load),
    .a     (in_a),
    .b     (in_b),
    .acc_d (acc_d)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a last beat closes the vector; the result leaves on out_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; no beat is taken while a result is held
  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
  end

  // Element counter restarts at 1 on the first beat of each vector
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = load ? CNT_W'(1) : cnt_q + CNT_W'(1);
    end
  end

`ifdef ML_DOT_SAT_EN
  localparam logic signed [63:0] OUT_MAX = sat_max(OUT_W);
  localparam logic signed [63:0] OUT_MIN = sat_min(OUT_W);

  logic signed [63:0] acc_wide;

  // Clamp the final sum into the signed result range
  always_comb begin
    acc_wide = 64'(acc_d);
    res_data = acc_d[OUT_W-1:0];
    res_sat  = 1'b0;
    if (acc_wide > OUT_MAX) begin
      res_data = OUT_MAX[OUT_W-1:0];
      res_sat  = 1'b1;
    end else if (acc_wide < OUT_MIN) begin
      res_data = OUT_MIN[OUT_W-1:0];
      res_sat  = 1'b1;
    end
  end
`else
  logic unused_acc_hi;

  // Plain truncation of the final sum; upper accumulator bits are dropped
  always_comb begin
    res_data      = acc_d[OUT_W-1:0];
    res_sat       = 1'b0;
    unused_acc_hi = ^acc_d;
  end
`endif

  // Result register captures on the last accepted beat and holds until replaced
  always_comb begin
    out_data_d = out_data_q;
    out_len_d  = out_len_q;
    out_sat_d  = out_sat_q;
    if (accept && in_last) begin
      out_data_d = res_data;
      out_len_d  = cnt_d;
      out_sat_d  = res_sat;
    end
  end

  // Counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      out_data_q <= '0;
      out_len_q  <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_len_q  <= out_len_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign out_data = out_data_q;
  assign out_len  = out_len_q;
  assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_ml_vec_dot_engine.sv
// Self-checking bench for ml_vec_dot_engine: directed vectors with literal
// expectations, then randomized vectors with random gaps, backpressure and resets.
module tb_ml_vec_dot_engine;

  localparam int DW = 16;
  localparam int AW = 40;
  localparam int OW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_a;
  logic signed [DW-1:0] in_b;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [CW-1:0]        out_len;
  logic                 out_sat;

  ml_vec_dot_engine #(
    .DATA_W (DW),
    .ACC_W  (AW),
    .OUT_W  (OW),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_sat   (out_sat)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: running sum of the current vector and the held result
  longint m_sum = 0;
  int     m_len = 0;
  bit     m_have = 1'b0;
  bit     m_zero = 1'b0;
  bit     m_acc = 1'b0;
  longint m_res = 0;
  int     m_rlen = 0;
  bit     m_rsat = 1'b0;
  bit     rnd_ready = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint wrap_acc(input longint v);
    logic [AW-1:0] t;
    t = v[AW-1:0];
    return longint'($signed(t));
  endfunction

  task automatic finalize(input longint s);
`ifdef ML_DOT_SAT_EN
    if (s > 32767) begin
      m_res = 32767; m_rsat = 1'b1;
    end else if (s < -32768) begin
      m_res = -32768; m_rsat = 1'b1;
    end else begin
      m_res = s; m_rsat = 1'b0;
    end
`else
    logic signed [OW-1:0] t;
    t = s[OW-1:0];
    m_res  = longint'(t);
    m_rsat = 1'b0;
`endif
  endtask

  task automatic model_update();
    longint p;
    m_acc = 1'b0;
    if (!rst_n) begin
      m_have = 1'b0; m_len = 0; m_sum = 0; m_zero = 1'b1;
    end else if (m_have) begin
      if (out_ready) m_have = 1'b0;
    end else if (in_valid) begin
      m_acc = 1'b1;
      p = longint'(in_a) * longint'(in_b);
      m_sum = wrap_acc((m_len == 0) ? p : m_sum + p);
      m_len++;
      if (in_last) begin
        finalize(m_sum);
        m_rlen = m_len;
        m_have = 1'b1;
        m_zero = 1'b0;
        m_len  = 0;
      end
    end
  endtask

  task automatic compare();
    check("in_ready", longint'(in_ready), longint'(!m_have));
    check("out_valid", longint'(out_valid), longint'(m_have));
    if (m_have) begin
      check("out_data", longint'(out_data), m_res);
      check("out_len", longint'(out_len), longint'(m_rlen));
      check("out_sat", longint'(out_sat), longint'(m_rsat));
    end else if (m_zero) begin
      check("rst_data", longint'(out_data), 0);
      check("rst_len", longint'(out_len), 0);
      check("rst_sat", longint'(out_sat), 0);
    end
  endtask

  task automatic step();
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic send_beat(input int a, input int b, input bit last, input int gap,
                           output int cyc);
    in_a = DW'(a); in_b = DW'(b); in_last = last; in_valid = 1'b1;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!m_acc && cyc < 60);
    if (!m_acc) check("beat_timeout", 0, 1);
    in_valid = 1'b0;
    in_a = DW'($urandom);
    in_b = DW'($urandom);
    in_last = 1'($urandom);
    repeat (gap) step();
  endtask

  int cyc;
  int len;
  int ra, rb;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);

    // Basic 3-element vector, held under backpressure
    out_ready = 1'b0;
    send_beat(1, 4, 1'b0, 0, cyc);
    send_beat(2, 5, 1'b0, 0, cyc);
    send_beat(3, 6, 1'b1, 0, cyc);
    check("basic_valid", longint'(out_valid), 1);
    check("basic_data", longint'(out_data), 32);
    check("basic_len", longint'(out_len), 3);
    check("basic_model", m_res, 32);

    // Backpressure for 5 cycles with the next beat already offered
    in_a = -16'sd7; in_b = 16'sd3; in_last = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      step();
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_data", longint'(out_data), 32);
      check("bp_len", longint'(out_len), 3);
    end
    out_ready = 1'b1;
    send_beat(-7, 3, 1'b1, 0, cyc);
    check("bubble_cycles", longint'(cyc), 2);
    check("len1_data", longint'(out_data), -21);
    check("len1_len", longint'(out_len), 1);
    check("len1_model", m_res, -21);
    step();

    // Same data as the basic case with idle gaps between beats
    send_beat(1, 4, 1'b0, 3, cyc);
    send_beat(2, 5, 1'b0, 2, cyc);
    send_beat(3, 6, 1'b1, 0, cyc);
    check("gap_data", longint'(out_data), 32);
    check("gap_len", longint'(out_len), 3);
    step();

    // Reset after two beats discards the partial sum
    send_beat(5, 5, 1'b0, 0, cyc);
    send_beat(6, 6, 1'b0, 0, cyc);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("midrst_out_valid", longint'(out_valid), 0);
    send_beat(2, 2, 1'b1, 0, cyc);
    check("midrst_data", longint'(out_data), 4);
    check("midrst_len", longint'(out_len), 1);
    step();

    // Two full-scale products overflow the 16-bit result
    send_beat(32767, 32767, 1'b0, 0, cyc);
    send_beat(32767, 32767, 1'b1, 0, cyc);
`ifdef ML_DOT_SAT_EN
    check("sat_data", longint'(out_data), 32767);
    check("sat_flag", longint'(out_sat), 1);
`else
    check("trunc_data", longint'(out_data), 2);
    check("trunc_flag", longint'(out_sat), 0);
`endif
    step();

    // Randomized vectors with random gaps, backpressure and occasional reset
    rnd_ready = 1'b1;
    for (int v = 0; v < 300; v++) begin
      len = $urandom_range(1, 8);
      for (int e = 0; e < len; e++) begin
        if ($urandom_range(0, 3) == 0) begin
          ra = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
          rb = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        end else begin
          ra = int'($signed(16'($urandom)));
          rb = int'($signed(16'($urandom)));
        end
        send_beat(ra, rb, (e == len - 1), ($urandom_range(0, 4) == 0) ? 2 : 0, cyc);
        if ($urandom_range(0, 150) == 0) begin
          rst_n = 1'b0;
          step();
          rst_n = 1'b1;
        end
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
